// File: rtl/serial2parallel_sr.sv
// ---------------------------------------------------------------------------
// serial2parallel_sr
//
// Purpose:
//   Serial-to-parallel shift register. Collects DATA_WIDTH serial bits, LSB
//   first, into a word and presents it in a holding register with a
//   valid/ready handshake. A frame begins with the bit sampled on a cycle
//   that has both start and din_en high, and it ends when the last bit is
//   sampled. Cycles with din_en low stall assembly indefinitely.
//
// Handshake (valid/ready):
//   dout_valid rises on the edge that completes a frame. dout and parity_err
//   then hold steady until dout_valid & dout_ready is seen at a clock edge.
//   When a frame completes on that same edge, the new word is loaded and
//   dout_valid stays high. When a frame completes while dout_valid=1 and
//   dout_ready=0, the frame is dropped and the sticky overflow flag is set.
//
// Optional feature (macro S2P_PARITY_EN):
//   With the macro defined, one extra even-parity bit follows the data bits.
//   The frame completes when that bit is sampled, and
//   parity_err = XOR(data bits, parity bit).
//   With the macro undefined there is no PARITY state and parity_err is 0.
//
// Ports:
//   clk         in   clock, rising edge
//   resetn      in   synchronous active-low reset, priority over all inputs
//   din         in   serial data bit
//   din_en      in   bit strobe; din/start are sampled only when it is high
//   start       in   frame start (qualified by din_en); marks bit 0
//   dout        out  [DATA_WIDTH] assembled word (holding register)
//   dout_valid  out  dout holds an unconsumed word
//   dout_ready  in   consumer accepts dout
//   busy        out  frame assembly in progress (state != IDLE)
//   overflow    out  sticky: a completed frame was dropped
//   parity_err  out  parity status of the word in dout
//   dbg_state   out  [2] current FSM state (0 IDLE, 1 SHIFT, 2 PARITY)
// ---------------------------------------------------------------------------
module serial2parallel_sr #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  din,
   input  logic                  din_en,
   input  logic                  start,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  busy,
   output logic                  overflow,
   output logic                  parity_err,
   output logic [1:0]            dbg_state
);

   localparam int              CW       = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1
`ifdef S2P_PARITY_EN
      ,
      ST_PARITY = 2'd2
`endif
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [CW-1:0]         r_count;
   logic [CW-1:0]         w_count_next;
   logic [DATA_WIDTH-1:0] r_asm;
   logic [DATA_WIDTH-1:0] w_asm_next;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_dout_valid;
   logic                  r_overflow;

   logic                  w_start;
   logic                  w_bit_ok;
   logic                  w_complete;
   logic [DATA_WIDTH-1:0] w_word;
   logic [DATA_WIDTH-1:0] w_bit_shifted;
   logic [DATA_WIDTH-1:0] w_bit0;

`ifdef S2P_PARITY_EN
   logic                  r_parity_err;
   logic                  w_word_par;
`endif

   assign w_start  = din_en & start;
   assign w_bit_ok = din_en & ~start;
   assign w_bit0   = {{(DATA_WIDTH-1){1'b0}}, din};
   // Unwritten assembly bits are always 0, so OR-ing in the shifted bit
   // places din at position r_count.
   assign w_bit_shifted = w_bit0 << r_count;

   // ---------------- next-state / datapath ----------------
   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_asm_next   = r_asm;
      w_complete   = 1'b0;
      w_word       = r_asm;
`ifdef S2P_PARITY_EN
      w_word_par   = 1'b0;
`endif
      if (w_start) begin
         // Restart from any state: partial bits are discarded.
         w_asm_next   = w_bit0;
         w_count_next = CW'(1);
         w_state_next = ST_SHIFT;
      end else if (w_bit_ok) begin
         case (r_state)
            ST_SHIFT: begin
               w_asm_next = r_asm | w_bit_shifted;
               if (r_count == LAST_BIT) begin
`ifdef S2P_PARITY_EN
                  w_count_next = r_count + CW'(1);
                  w_state_next = ST_PARITY;
`else
                  w_complete   = 1'b1;
                  w_word       = w_asm_next;
                  w_count_next = '0;
                  w_state_next = ST_IDLE;
`endif
               end else begin
                  w_count_next = r_count + CW'(1);
               end
            end
`ifdef S2P_PARITY_EN
            ST_PARITY: begin
               // din is the parity bit; even parity over data + parity.
               w_complete   = 1'b1;
               w_word       = r_asm;
               w_word_par   = (^r_asm) ^ din;
               w_count_next = '0;
               w_state_next = ST_IDLE;
            end
`endif
            default: ;
         endcase
      end
   end

   // ---------------- assembly state ----------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_asm   <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         r_asm   <= w_asm_next;
      end
   end

   // ---------------- holding register / handshake ----------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_overflow   <= 1'b0;
`ifdef S2P_PARITY_EN
         r_parity_err <= 1'b0;
`endif
      end else if (w_complete) begin
         if (!r_dout_valid || dout_ready) begin
            r_dout       <= w_word;
            r_dout_valid <= 1'b1;
`ifdef S2P_PARITY_EN
            r_parity_err <= w_word_par;
`endif
         end else begin
            // Consumer still holds the previous word: drop the new one.
            r_overflow <= 1'b1;
         end
      end else if (r_dout_valid && dout_ready) begin
         r_dout_valid <= 1'b0;
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign overflow   = r_overflow;
   assign busy       = (r_state != ST_IDLE);
   assign dbg_state  = r_state;
`ifdef S2P_PARITY_EN
   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: doc/serial2parallel_sr.md
SERIAL2PARALLEL_SR -- requirements
Module: serial2parallel_sr

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 16, deserialized word width in bits (legal range 2..64).
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: din  input  1  serial data bit, LSB of word first.
REQ-005 SHALL have port: din_en  input  1  bit strobe; din sampled only on cycles with din_en=1.
REQ-006 SHALL have port: start  input  1  frame start; qualified by din_en; marks the sampled bit as bit 0.
REQ-007 SHALL have port: dout  output  DATA_WIDTH  assembled word (holding register).
REQ-008 SHALL have port: dout_valid  output  1  dout holds an unconsumed word.
REQ-009 SHALL have port: dout_ready  input  1  consumer accepts dout when dout_valid=1.
REQ-010 SHALL have port: busy  output  1  frame assembly in progress (state != IDLE).
REQ-011 SHALL have port: overflow  output  1  sticky flag: completed frame dropped.
REQ-012 SHALL have port: parity_err  output  1  parity status of word in dout.

Function
REQ-013 SHALL implement states IDLE, SHIFT, PARITY (PARITY reachable only with S2P_PARITY_EN); bit counter width $clog2(DATA_WIDTH+1).
REQ-014 SHALL, in IDLE, ignore din_en without start; ignore start without din_en.
REQ-015 SHALL, on start&din_en in any state, discard partial bits, write din to bit 0, set count=1, enter SHIFT.
REQ-016 SHALL, in SHIFT on din_en&!start, write din to bit position count, increment count; din_en=0 cycles stall with no timeout.
REQ-017 SHALL treat sampling of bit DATA_WIDTH-1 (macro off) as frame completion, returning to IDLE on the same edge.
REQ-018 SHALL, on completion with dout_valid=0 or dout_valid&dout_ready, load dout and set dout_valid=1 on the same edge that samples the final bit (zero added latency).
REQ-019 SHALL, on completion with dout_valid=1 and dout_ready=0, drop the frame, keep dout/parity_err unchanged, set overflow=1.
REQ-020 SHALL clear dout_valid on dout_valid&dout_ready when no frame completes that cycle.
REQ-021 SHALL hold dout and parity_err stable while dout_valid=1 and dout_ready=0.
REQ-022 SHALL keep overflow set until reset; no other clear.
REQ-023 SHALL drive dout bits not yet written in a frame as 0 (assembly register cleared at each start).

Reset
REQ-024 SHALL, while resetn=0 at a clock edge, set state=IDLE, count=0, assembly register=0, dout=0, dout_valid=0, busy=0, overflow=0, parity_err=0.
REQ-025 SHALL abandon any frame in progress on reset; subsequent din_en without start SHALL produce no output.
REQ-026 SHALL give resetn priority over start, din_en and dout_ready.

Configuration
REQ-027 SHALL use macro S2P_PARITY_EN to compile in even-parity checking.
REQ-028 SHALL, with S2P_PARITY_EN defined, enter PARITY after bit DATA_WIDTH-1; next din_en&!start bit is parity; completion occurs on that edge; parity_err = XOR(data bits, parity bit).
REQ-029 SHALL, with S2P_PARITY_EN defined, treat start&din_en in PARITY as restart per REQ-015.
REQ-030 SHALL, without S2P_PARITY_EN, omit PARITY state and tie parity_err to 0.

Verification
REQ-031 SHALL cover: DATA_WIDTH=8, start+8 consecutive din_en bits of 0xA5 LSB-first, dout_ready=1 -> dout=0xA5, dout_valid=1 exactly one cycle, busy high for 7 cycles.
REQ-032 SHALL cover: 3 bits of 0xFF then start with 0x3C -> single dout_valid with dout=0x3C.
REQ-033 SHALL cover: dout_ready=0, frames 0x11 then 0x22 -> dout stays 0x11, overflow=1; dout_ready=1 -> dout_valid falls next edge, overflow stays 1.
REQ-034 SHALL cover: dout_valid=1 with 0x11, dout_ready=1 on final-bit edge of 0x22 -> dout=0x22, dout_valid remains 1, overflow=0.
REQ-035 SHALL cover: 4 bits sampled, resetn=0 one cycle, 10 further din_en bits without start -> dout_valid=0, busy=0, dout=0.
REQ-036 SHALL cover (S2P_PARITY_EN): 0xA5 with parity bit 1 -> parity_err=1; with parity bit 0 -> parity_err=0; dout_valid asserted on parity-bit edge.
